// File: rtl/homo_pkg.sv
// Shared types and defaults for the homogeneity window scheduler.
package homo_pkg;

    localparam int unsigned WIN_DEF      = 5;
    localparam int unsigned PIPE_LAT_DEF = 33;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Frame is in progress in these states
    function automatic logic is_busy(input state_t s);
        return (s == FILL) || (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/raster_counter.sv
// Raster-order column/row position of the next accepted pixel.
module raster_counter #(
    parameter  int unsigned IMG_W = 640,
    parameter  int unsigned IMG_H = 480,
    localparam int unsigned XW    = $clog2(IMG_W),
    localparam int unsigned YW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [XW-1:0] col,
    output logic [YW-1:0] row,
    output logic          last
);

    logic col_end;
    logic row_end;

    assign col_end = (col == XW'(IMG_W - 1));
    assign row_end = (row == YW'(IMG_H - 1));
    assign last    = col_end && row_end;

    // Step one pixel; wrap column into the next row, wrap row at frame end
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + YW'(1);
            end else begin
                col <= col + XW'(1);
            end
        end
    end

endmodule

// File: rtl/homo_scheduler.sv
// Frame scheduler: issues window-centre coordinates to the homogeneity
// compare stage and tracks results returning from the buffer chain.
module homo_scheduler
    import homo_pkg::*;
#(
    parameter  int unsigned IMG_W    = 640,
    parameter  int unsigned IMG_H    = 480,
    parameter  int unsigned WIN      = WIN_DEF,
    parameter  int unsigned PIPE_LAT = PIPE_LAT_DEF,
    localparam int unsigned XW       = $clog2(IMG_W),
    localparam int unsigned YW       = $clog2(IMG_H)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_pix_valid,
    input  logic          i_homo_valid,
    output logic          o_win_valid,
    output logic [XW-1:0] o_win_x,
    output logic [YW-1:0] o_win_y,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    localparam int unsigned OW    = $clog2(IMG_W * IMG_H) + 1;
    localparam int unsigned DW    = $clog2(PIPE_LAT + 5);
    localparam int unsigned EDGE  = WIN - 1;
    localparam int unsigned HALF  = (WIN - 1) / 2;
    localparam int unsigned DR_TO = PIPE_LAT + 4;

    state_t          state_q;
    state_t          state_d;
    logic [OW-1:0]   outstanding_q;
    logic [OW-1:0]   outstanding_d;
    logic [DW-1:0]   drain_q;
    logic [DW-1:0]   drain_d;
    logic            win_valid_d;
    logic [XW-1:0]   win_x_d;
    logic [YW-1:0]   win_y_d;
    logic            busy_d;
    logic            done_d;
    logic            err_d;
    logic            accept;
    logic            clear;

    logic [XW-1:0]   col;
    logic [YW-1:0]   row;
    logic            last;

    raster_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_raster (
        .clk     (i_clk),
        .rst     (i_rst),
        .clear   (clear),
        .advance (accept),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    // Next-state, window issue, outstanding tracking and error detection
    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        drain_d       = '0;
        win_valid_d   = 1'b0;
        win_x_d       = o_win_x;
        win_y_d       = o_win_y;
        err_d         = o_err;
        clear         = 1'b0;
        accept        = i_pix_valid && ((state_q == FILL) || (state_q == RUN));

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = FILL;
                    clear   = 1'b1;
                end
            end
            FILL: begin
                if (accept && last) begin
                    state_d = DRAIN;
                end else if (row == YW'(EDGE)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_d = drain_q + DW'(1);
                // The final window issues the cycle DRAIN is entered
                if ((outstanding_q == '0) && !o_win_valid) begin
                    state_d = DONE;
                end else if (drain_q == DW'(DR_TO)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Issued windows vs returned results; a return with nothing in flight is an error
        if (clear) begin
            outstanding_d = '0;
            err_d         = 1'b0;
        end else if (o_win_valid && !i_homo_valid) begin
            outstanding_d = outstanding_q + OW'(1);
        end else if (!o_win_valid && i_homo_valid) begin
            if (outstanding_q == '0) begin
                err_d = 1'b1;
            end else begin
                outstanding_d = outstanding_q - OW'(1);
            end
        end

        // Window centre once a full WIN x WIN neighbourhood has arrived
        if (accept && (col >= XW'(EDGE)) && (row >= YW'(EDGE))) begin
            win_valid_d = 1'b1;
            win_x_d     = col - XW'(HALF);
            win_y_d     = row - YW'(HALF);
        end

        busy_d = is_busy(state_d);
        done_d = (state_d == DONE);
    end

    // State register and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= IDLE;
            outstanding_q <= '0;
            drain_q       <= '0;
            o_win_valid   <= 1'b0;
            o_win_x       <= '0;
            o_win_y       <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            drain_q       <= drain_d;
            o_win_valid   <= win_valid_d;
            o_win_x       <= win_x_d;
            o_win_y       <= win_y_d;
            o_busy        <= busy_d;
            o_done        <= done_d;
            o_err         <= err_d;
        end
    end

endmodule

// File: tb/tb_homo_scheduler.sv
// Self-checking bench for homo_scheduler on a small 8x6 frame.
module tb_homo_scheduler;

    localparam int IMG_W    = 8;
    localparam int IMG_H    = 6;
    localparam int WIN      = 5;
    localparam int PIPE_LAT = 33;
    localparam int XW       = $clog2(IMG_W);
    localparam int YW       = $clog2(IMG_H);

    logic          clk;
    logic          i_rst;
    logic          i_start;
    logic          i_pix_valid;
    logic          i_homo_valid;
    logic          o_win_valid;
    logic [XW-1:0] o_win_x;
    logic [YW-1:0] o_win_y;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    int n_checks = 0;
    int n_errors = 0;

    // Result-return model state and observation log
    logic [PIPE_LAT:0] pipe;
    bit                inject_homo;
    bit                drop_pending;
    int                obs_x[$];
    int                obs_y[$];
    int                first_win_pix;
    int                pix_sent;
    int                done_cnt;

    homo_scheduler #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .WIN      (WIN),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_pix_valid  (i_pix_valid),
        .i_homo_valid (i_homo_valid),
        .o_win_valid  (o_win_valid),
        .o_win_x      (o_win_x),
        .o_win_y      (o_win_y),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle: observe outputs mid-cycle, return each window PIPE_LAT cycles later
    task automatic tick();
        @(negedge clk);
        if (o_win_valid) begin
            obs_x.push_back(int'(o_win_x));
            obs_y.push_back(int'(o_win_y));
            if (first_win_pix < 0) first_win_pix = pix_sent;
            if (drop_pending) begin
                drop_pending = 1'b0;
                pipe = pipe << 1;
            end else begin
                pipe = {pipe[PIPE_LAT-1:0], 1'b1};
            end
        end else begin
            pipe = pipe << 1;
        end
        if (o_done) done_cnt++;
        i_homo_valid = pipe[PIPE_LAT] | inject_homo;
    endtask

    // One full frame; mode 0 back-to-back, 1 alternate cycles, 2 random gaps
    task automatic run_frame(input int mode, input bit start_mid, input bit exp_err, input string tag);
        int exp_x[$];
        int exp_y[$];
        int wait_cnt;
        int gaps;
        int bad_idx;
        exp_x.delete();
        exp_y.delete();
        obs_x.delete();
        obs_y.delete();
        first_win_pix = -1;
        pix_sent = 0;
        done_cnt = 0;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                if (r >= WIN - 1 && c >= WIN - 1) begin
                    exp_x.push_back(c - (WIN - 1) / 2);
                    exp_y.push_back(r - (WIN - 1) / 2);
                end

        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_checks++;
        if (o_busy !== 1'b1 || o_err !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_start: busy=%b err=%b, required busy=1 err=0", tag, o_busy, o_err);
        end

        for (int p = 0; p < IMG_W * IMG_H; p++) begin
            gaps = (mode == 1) ? ((p == 0) ? 0 : 1) : (mode == 2) ? int'($urandom_range(0, 3)) : 0;
            for (int g = 0; g < gaps; g++) tick();
            i_pix_valid = 1'b1;
            i_start = start_mid && (p == 39);
            pix_sent++;
            tick();
            i_pix_valid = 1'b0;
            i_start = 1'b0;
        end

        wait_cnt = 0;
        while (done_cnt == 0 && wait_cnt < PIPE_LAT + 60) begin
            tick();
            wait_cnt++;
        end

        n_checks++;
        if (done_cnt == 0) begin
            n_errors++;
            $display("FAIL %s_done_timeout: no o_done after %0d cycles, required a pulse", tag, wait_cnt);
        end else if (exp_err) begin
            if (wait_cnt < PIPE_LAT + 4 || wait_cnt > PIPE_LAT + 8) begin
                n_errors++;
                $display("FAIL %s_watchdog_delay: done after %0d cycles, required %0d..%0d",
                         tag, wait_cnt, PIPE_LAT + 4, PIPE_LAT + 8);
            end
        end else if (wait_cnt >= PIPE_LAT + 4) begin
            n_errors++;
            $display("FAIL %s_drain_delay: done after %0d cycles, required < %0d", tag, wait_cnt, PIPE_LAT + 4);
        end

        n_checks++;
        if (o_err !== exp_err) begin
            n_errors++;
            $display("FAIL %s_err: err=%b, required %b", tag, o_err, exp_err);
        end

        n_checks++;
        if (obs_x.size() != exp_x.size()) begin
            n_errors++;
            $display("FAIL %s_win_count: got %0d windows, required %0d", tag, obs_x.size(), exp_x.size());
        end

        bad_idx = -1;
        for (int i = 0; i < exp_x.size() && i < obs_x.size(); i++)
            if (bad_idx < 0 && (obs_x[i] != exp_x[i] || obs_y[i] != exp_y[i])) bad_idx = i;
        n_checks++;
        if (bad_idx >= 0) begin
            n_errors++;
            $display("FAIL %s_win_order: window %0d at (%0d,%0d), required (%0d,%0d)", tag, bad_idx,
                     obs_x[bad_idx], obs_y[bad_idx], exp_x[bad_idx], exp_y[bad_idx]);
        end

        n_checks++;
        if (first_win_pix != (WIN - 1) * IMG_W + WIN) begin
            n_errors++;
            $display("FAIL %s_first_win: first window after pixel %0d, required %0d",
                     tag, first_win_pix, (WIN - 1) * IMG_W + WIN);
        end

        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (done_cnt != 1 || o_busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_after: done pulses=%0d busy=%b, required 1 and 0", tag, done_cnt, o_busy);
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({o_win_valid, o_win_x, o_win_y, o_busy, o_done, o_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: valid=%b x=%0d y=%0d busy=%b done=%b err=%b, required all 0",
                     o_win_valid, o_win_x, o_win_y, o_busy, o_done, o_err);
        end
        i_rst = 1'b0;
        tick();
        n_checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", o_busy, o_done);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(0, 1'b0, 1'b0, "b2b");
    endtask

    task automatic test_toggle();
        run_frame(1, 1'b0, 1'b0, "toggle");
    endtask

    task automatic test_idle_homo();
        inject_homo = 1'b1;
        tick();
        inject_homo = 1'b0;
        tick();
        n_checks++;
        if (o_err !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_homo_err: err=%b, required 1", o_err);
        end
        for (int i = 0; i < 6; i++) tick();
        n_checks++;
        if (o_err !== 1'b1) begin
            n_errors++;
            $display("FAIL idle_homo_sticky: err=%b, required 1", o_err);
        end
        run_frame(0, 1'b0, 1'b0, "after_err");
    endtask

    task automatic test_start_in_run();
        run_frame(0, 1'b1, 1'b0, "start_in_run");
    endtask

    task automatic test_random();
        run_frame(2, 1'b0, 1'b0, "rand0");
        run_frame(2, 1'b0, 1'b0, "rand1");
    endtask

    task automatic test_watchdog();
        drop_pending = 1'b1;
        run_frame(int'($urandom_range(0, 1)), 1'b0, 1'b1, "watchdog");
    endtask

    task automatic test_mid_reset();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int p = 0; p < 20; p++) begin
            i_pix_valid = 1'b1;
            tick();
        end
        i_pix_valid = 1'b0;
        i_rst = 1'b1;
        tick();
        n_checks++;
        if ({o_win_valid, o_win_x, o_win_y, o_busy, o_done, o_err} !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_outputs: valid=%b x=%0d y=%0d busy=%b done=%b err=%b, required all 0",
                     o_win_valid, o_win_x, o_win_y, o_busy, o_done, o_err);
        end
        i_rst = 1'b0;
        tick();
        run_frame(0, 1'b0, 1'b0, "post_reset");
    endtask

    initial begin
        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_pix_valid  = 1'b0;
        i_homo_valid = 1'b0;
        inject_homo  = 1'b0;
        drop_pending = 1'b0;
        pipe         = '0;
        pix_sent     = 0;
        done_cnt     = 0;
        first_win_pix = -1;
        test_reset();
        test_back_to_back();
        test_toggle();
        test_idle_homo();
        test_start_in_run();
        test_random();
        test_watchdog();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/homo_scheduler.md
HOMO_SCHEDULER -- requirements
Module: homo_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 640, frame width in pixels.
REQ-002 SHALL have parameter IMG_H, default 480, frame height in pixels.
REQ-003 SHALL have parameter WIN, default 5, square window edge; IMG_W and IMG_H are both at least WIN.
REQ-004 SHALL have parameter PIPE_LAT, default 33, cycles from o_win_valid to the matching i_homo_valid (1 compare stage + 32 buffer stages).
REQ-005 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_start  input  1  single-cycle frame start request.
REQ-008 SHALL have port i_pix_valid  input  1  one stereo pixel pair enters the window generator this cycle, raster order.
REQ-009 SHALL have port i_homo_valid  input  1  one homogeneity result returns from the buffer chain.
REQ-010 SHALL have port o_win_valid  output  1  drives the homogeneity compare stage i_valid.
REQ-011 SHALL have port o_win_x  output  clog2(IMG_W)  window-centre column.
REQ-012 SHALL have port o_win_y  output  clog2(IMG_H)  window-centre row.
REQ-013 SHALL have port o_busy  output  1  high in FILL, RUN, DRAIN.
REQ-014 SHALL have port o_done  output  1  one-cycle frame-complete pulse.
REQ-015 SHALL have port o_err  output  1  sticky protocol error flag.

Function
REQ-016 SHALL implement FSM states IDLE, FILL, RUN, DRAIN, DONE.
REQ-017 IDLE->FILL on i_start; clears col/row counters, outstanding counter, o_err; i_pix_valid ignored in IDLE and DONE.
REQ-018 i_start outside IDLE SHALL be ignored.
REQ-019 Per accepted pixel: col increments, wraps IMG_W-1->0 with row increment.
REQ-020 FILL->RUN when row reaches WIN-1; RUN->DRAIN on acceptance of pixel (IMG_W-1, IMG_H-1).
REQ-021 Pixel accepted at col>=WIN-1 and row>=WIN-1 SHALL assert o_win_valid next cycle (latency 1, registered), with o_win_x=col-(WIN-1)/2, o_win_y=row-(WIN-1)/2.
REQ-022 o_win_valid low in all other cycles; o_win_x/o_win_y hold last value when o_win_valid low.
REQ-023 Outstanding counter (width clog2(IMG_W*IMG_H)+1): +1 on o_win_valid, -1 on i_homo_valid, unchanged when both same cycle.
REQ-024 i_homo_valid with outstanding==0 and no same-cycle o_win_valid SHALL set o_err; counter stays 0.
REQ-025 DRAIN->DONE when outstanding==0; DONE lasts one cycle with o_done=1, then IDLE.
REQ-026 DRAIN watchdog: if DRAIN persists more than PIPE_LAT+4 cycles, set o_err and force DONE.
REQ-027 Total windows per frame SHALL equal (IMG_W-WIN+1)*(IMG_H-WIN+1).

Reset
REQ-028 i_rst at any clock edge, including mid-frame, SHALL force IDLE and zero counters.
REQ-029 Reset values: o_win_valid=0, o_win_x=0, o_win_y=0, o_busy=0, o_done=0, o_err=0.

Structure
REQ-030 FSM state enum and WIN/PIPE_LAT defaults SHALL live in shared package homo_pkg.
REQ-031 Raster col/row counter SHALL be sub-module raster_counter (inputs: clk, rst, clear, advance; outputs: col, row, last).
REQ-032 No datapath arithmetic on pixel values in this block.

Verification (IMG_W=8, IMG_H=6, WIN=5, PIPE_LAT=33)
REQ-033 Start, 48 back-to-back pixels, model returns results 33 cycles later -> first o_win_valid cycle after 37th pixel with (2,2), 8 windows total, o_done once, o_err=0.
REQ-034 Same frame with i_pix_valid toggling every other cycle -> same 8 windows, centres (2..5,2),(2..5,3) in order.
REQ-035 i_homo_valid pulsed in IDLE -> o_err=1, stays 1 until next i_start.
REQ-036 Model drops one result -> DRAIN watchdog after 37 cycles, o_err=1, o_done pulses.
REQ-037 i_rst asserted after 20th pixel -> all outputs 0 next cycle, state IDLE; fresh frame then completes with 8 windows.
REQ-038 i_start during RUN -> ignored, counters continue, frame totals unchanged.
